// File: rtl/vme_bus_arbiter_pkg.sv
// vme_arb_pkg: shared FSM state type, grant encodings and read-data fill value
// for the two-master VME bus arbiter.
package vme_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0 = 2'b01;
    localparam logic [1:0] GNT_M1 = 2'b10;
    localparam logic RDATA_FILL = 1'b0;
endpackage

// File: rtl/vme_bus_arbiter_if.sv
// vme_bus_arbiter_if: both master request/response channels plus the VME strobe/done bus.
// The arbiter takes the master modport; the environment takes the slave modport.
interface vme_bus_arbiter_if #(parameter int AW = 18, parameter int DW = 32);
    logic          m0_req, m0_we, m0_ack, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_ack, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] VMEAddr;
    logic [DW-1:0] VMEWrData, VMERdData;
    logic          VMERdMem, VMEWrMem, VMERdDone, VMEWrDone, VMERdError, VMEWrError;
    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata,
        output m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
        output VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        input  VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
    );
    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata,
        input  m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata,
        input  VMEAddr, VMEWrData, VMERdMem, VMEWrMem,
        output VMERdData, VMERdDone, VMEWrDone, VMERdError, VMEWrError
    );
endinterface

// File: rtl/vme_bus_arbiter_rr2.sv
// vme_arb_rr2: two-input round-robin picker; on a tie the master that did not
// win last time is chosen. last_grant resets to m1 so m0 wins the first tie.
module vme_arb_rr2
    import vme_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       load,
    output logic [1:0] gnt
);
    logic [1:0] last_q;
    always_comb gnt = (&req) ? ((last_q == GNT_M1) ? GNT_M0 : GNT_M1) : req;
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) last_q <= GNT_M1;
        else if (load && |req) last_q <= gnt;
    end
endmodule

// File: rtl/vme_bus_arbiter.sv
// vme_bus_arbiter: grants one of two masters, issues a single-cycle VME strobe,
// waits for the matching done/error or a timeout, and returns a one-cycle ack.
module vme_bus_arbiter
    import vme_arb_pkg::*;
#(
    parameter int AW      = 18,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                Clk,
    input  logic                rst_n,
    vme_bus_arbiter_if.master   bus,
    output logic [1:0]          grant,
    output logic                timeout_evt
);
    state_e        state_q;
    logic [TO_W-1:0] cnt_q;
    logic          wr_q;
    logic [1:0]    ack_q, err_q, req, pick;
    logic [DW-1:0] rd0_q, rd1_q, rd_val, wdata_sel;
    logic [AW-1:0] addr_sel;
    logic          we_sel, done_hit, err_hit, fin, to_hit, rsp;
    assign req = {bus.m1_req, bus.m0_req};
    vme_arb_rr2 u_rr (.Clk(Clk), .rst_n(rst_n), .req(req), .load(state_q == IDLE), .gnt(pick));
    // Only the done/error of the issued direction counts.
    always_comb begin
        we_sel    = pick[1] ? bus.m1_we : bus.m0_we;
        addr_sel  = pick[1] ? bus.m1_addr : bus.m0_addr;
        wdata_sel = pick[1] ? bus.m1_wdata : bus.m0_wdata;
        done_hit  = wr_q ? bus.VMEWrDone : bus.VMERdDone;
        err_hit   = wr_q ? bus.VMEWrError : bus.VMERdError;
        fin       = done_hit | err_hit;
        to_hit    = state_q == WAIT && !fin && cnt_q == TO_W'(TIMEOUT - 1);
        rsp       = (state_q == ISSUE || state_q == WAIT) && (fin || to_hit);
        rd_val    = (!wr_q && done_hit && !err_hit) ? bus.VMERdData : {DW{RDATA_FILL}};
    end
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            grant         <= GNT_NONE;
            timeout_evt   <= 1'b0;
            ack_q         <= GNT_NONE;
            err_q         <= GNT_NONE;
            rd0_q         <= '0;
            rd1_q         <= '0;
            bus.VMEAddr   <= '0;
            bus.VMEWrData <= '0;
            bus.VMERdMem  <= 1'b0;
            bus.VMEWrMem  <= 1'b0;
        end else begin
            bus.VMERdMem <= 1'b0;
            bus.VMEWrMem <= 1'b0;
            timeout_evt  <= to_hit;
            ack_q        <= rsp ? grant : GNT_NONE;
            err_q        <= (rsp && (err_hit || to_hit)) ? grant : GNT_NONE;
            rd0_q        <= (rsp && grant[0]) ? rd_val : {DW{RDATA_FILL}};
            rd1_q        <= (rsp && grant[1]) ? rd_val : {DW{RDATA_FILL}};
            case (state_q)
                IDLE: if (|req) begin
                    state_q       <= ISSUE;
                    grant         <= pick;
                    wr_q          <= we_sel;
                    bus.VMEAddr   <= addr_sel;
                    bus.VMEWrData <= wdata_sel;
                    bus.VMEWrMem  <= we_sel;
                    bus.VMERdMem  <= !we_sel;
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= fin ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + TO_W'(1);
                    if (fin || to_hit) state_q <= RESP;
                end
                default: begin
                    state_q <= IDLE;
                    grant   <= GNT_NONE;
                end
            endcase
        end
    end
    assign bus.m0_ack   = ack_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_rdata = rd0_q;
    assign bus.m1_rdata = rd1_q;
endmodule

// File: tb/tb_vme_bus_arbiter.sv
// tb_vme_bus_arbiter: directed transfers against the arbiter with hand-computed
// latencies, grants, error flags and read data.
module tb_vme_bus_arbiter;
    logic       Clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       timeout_evt;
    int         checks = 0;
    int         failures = 0;
    vme_bus_arbiter_if #(.AW(18), .DW(32)) bus ();
    vme_bus_arbiter #(.AW(18), .DW(32), .TIMEOUT(255), .TO_W(8)) dut (
        .Clk(Clk), .rst_n(rst_n), .bus(bus), .grant(grant), .timeout_evt(timeout_evt)
    );
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // k: cycles after the strobe that the slave answers (-1 = never)
    task automatic xfer(input int m, input bit we, input logic [17:0] addr, input logic [31:0] wd,
                        input int k, input bit both_err, input bit stray, input logic [31:0] rdv,
                        input bit keep, input int lat, input bit e_err, input bit e_to);
        logic [31:0] e_rd;
        int got_lat, strobes, tos;
        e_rd = (!we && !e_err) ? rdv : 32'h0;
        got_lat = -1; strobes = 0; tos = 0;
        if (m == 0) begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
        end else begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
        end
        @(negedge Clk);
        check("strobe_wr", bus.VMEWrMem, we);
        check("strobe_rd", bus.VMERdMem, !we);
        check("vme_addr", bus.VMEAddr, addr);
        check("grant", grant, (m == 0) ? 64'd1 : 64'd2);
        if (we) check("vme_wdata", bus.VMEWrData, wd);
        for (int t = 0; t < 300 && got_lat < 0; t++) begin
            if (t == k) begin
                if (we) begin bus.VMEWrDone = 1'b1; bus.VMEWrError = both_err; end
                else begin bus.VMERdDone = 1'b1; bus.VMERdError = both_err; bus.VMERdData = rdv; end
            end
            if (stray && t == 0) begin
                if (we) bus.VMERdDone = 1'b1;
                else bus.VMEWrDone = 1'b1;
            end
            @(negedge Clk);
            bus.VMEWrDone = 1'b0; bus.VMERdDone = 1'b0; bus.VMEWrError = 1'b0; bus.VMERdError = 1'b0;
            strobes += int'(bus.VMEWrMem | bus.VMERdMem);
            tos += int'(timeout_evt);
            if (bus.m0_ack | bus.m1_ack) begin
                got_lat = t + 1;
                check("ack", (m == 0) ? bus.m0_ack : bus.m1_ack, 1);
                check("other_ack", (m == 0) ? bus.m1_ack : bus.m0_ack, 0);
                check("err", (m == 0) ? bus.m0_err : bus.m1_err, e_err);
                check("rdata", (m == 0) ? bus.m0_rdata : bus.m1_rdata, e_rd);
                check("other_rdata", (m == 0) ? bus.m1_rdata : bus.m0_rdata, 0);
                check("timeout_evt", timeout_evt, e_to);
                if (!keep) begin bus.m0_req = 1'b0; bus.m1_req = 1'b0; end
            end
        end
        check("ack_latency", got_lat, lat);
        check("extra_strobes", strobes, 0);
        check("timeout_pulses", tos, e_to);
        @(negedge Clk);
        check("idle_grant", grant, 0);
        check("idle_ack", bus.m0_ack | bus.m1_ack, 0);
    endtask

    initial begin
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.VMERdData = '0; bus.VMERdDone = 0; bus.VMEWrDone = 0; bus.VMERdError = 0; bus.VMEWrError = 0;
        repeat (2) @(negedge Clk);
        check("rst_grant", grant, 0);
        check("rst_wrmem", bus.VMEWrMem, 0);
        check("rst_rdmem", bus.VMERdMem, 0);
        check("rst_ack", {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}, 0);
        check("rst_addr", bus.VMEAddr, 0);
        check("rst_rdata", bus.m0_rdata, 0);
        check("rst_timeout", timeout_evt, 0);
        rst_n = 1'b1;
        @(negedge Clk);
        xfer(0, 1'b1, 18'h00001, 32'hA5A5_00FF, 2, 0, 0, 32'h0, 0, 3, 0, 0);
        xfer(1, 1'b0, 18'h00000, 32'h0, 1, 0, 0, 32'h0000_0042, 0, 2, 0, 0);
        bus.m1_req = 1'b1;
        xfer(0, 1'b0, 18'h00010, 32'h0, 0, 0, 0, 32'h1111_0000, 1, 1, 0, 0);
        xfer(1, 1'b1, 18'h00020, 32'h2222_2222, 0, 0, 0, 32'h0, 1, 1, 0, 0);
        xfer(0, 1'b1, 18'h00030, 32'h3333_3333, 0, 0, 0, 32'h0, 1, 1, 0, 0);
        xfer(1, 1'b0, 18'h00040, 32'h0, 0, 0, 0, 32'h4444_0004, 0, 1, 0, 0);
        xfer(0, 1'b0, 18'h00050, 32'h0, -1, 0, 0, 32'hDEAD_BEEF, 0, 256, 1, 1);
        bus.VMERdDone = 1'b1; bus.VMERdData = 32'h5555_5555;
        @(negedge Clk);
        bus.VMERdDone = 1'b0;
        check("late_done_ack", bus.m0_ack | bus.m1_ack, 0);
        check("late_done_grant", grant, 0);
        xfer(1, 1'b0, 18'h00060, 32'h0, 255, 0, 0, 32'h0000_0066, 0, 256, 0, 0);
        xfer(0, 1'b1, 18'h00070, 32'h7777_7777, 1, 1, 1, 32'h0, 0, 2, 1, 0);
        bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 18'h00003; bus.m0_wdata = 32'hCAFE_0003;
        repeat (3) @(negedge Clk);
        rst_n = 1'b0;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_addr", bus.VMEAddr, 0);
        check("midrst_wdata", bus.VMEWrData, 0);
        check("midrst_outs", {bus.m0_ack, bus.m0_err, bus.VMEWrMem, bus.VMERdMem, timeout_evt}, 0);
        bus.m0_req = 1'b0;
        @(negedge Clk);
        rst_n = 1'b1;
        check("midrst_no_ack", bus.m0_ack, 0);
        @(negedge Clk);
        xfer(1, 1'b0, 18'h00005, 32'h0, 0, 0, 0, 32'h0000_1234, 0, 1, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vme_bus_arbiter.md
Name: vme_bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of one generated register-bank slave that uses the VME-style strobe/done bus.
- Round-robin grants one master at a time and issues a single-cycle VMERdMem/VMEWrMem strobe with registered address and data.
- Waits for VMERdDone/VMEWrDone or VMERdError/VMEWrError, or a timeout, then returns a one-cycle ack/err and read data to the granted master.
- Sits between CPU-side and DMA/maintenance-side masters and the register bank.

Parameters:
- AW, 18, address width; maps to VMEAddr[19:2].
- DW, 32, data width.
- TIMEOUT, 255, cycles in WAIT before a forced error; must be ≥1.
- TO_W, 8, timeout counter width; 2**TO_W > TIMEOUT.

Ports:
- Clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  request; held until that master's ack or err
- m0_we / m1_we  in  1  1=write, 0=read; stable while req
- m0_addr / m1_addr  in  AW  word address
- m0_wdata / m1_wdata  in  DW  write data
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  one-cycle error pulse, coincident with ack
- m0_rdata / m1_rdata  out  DW  read data, valid when ack=1
- VMEAddr  out  AW  slave address
- VMEWrData  out  DW  slave write data
- VMERdMem / VMEWrMem  out  1  single-cycle read/write strobe
- VMERdData  in  DW  slave read data
- VMERdDone / VMEWrDone  in  1  slave completion
- VMERdError / VMEWrError  in  1  slave error
- grant  out  2  one-hot current owner; 00 when idle
- timeout_evt  out  1  one-cycle pulse when a timeout fires

Behaviour:
- Reset: clock is Clk; reset is asynchronous and active-low on rst_n. All outputs are 0. State=IDLE, counter=0, last_grant=m1, so m0 wins the first tie.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick the winner: a sole requester wins; if both request, the master that is not last_grant wins.
  - Latch we/addr/wdata into VMEAddr/VMEWrData.
  - Set grant and last_grant, then go to ISSUE.
  - If no req, stay in IDLE.
- ISSUE (exactly one cycle):
  - VMEWrMem=we or VMERdMem=!we; the strobe is high only in this state.
  - Counter is cleared.
  - Done/Error for the active direction is sampled here too; if seen, go to RESP, else go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - Active Done or Error → RESP.
  - Counter==TIMEOUT-1 with no Done → RESP with err=1 and timeout_evt pulse.
- Direction qualification: only the Done/Error matching the issued direction counts. The other direction's signals are ignored.
- RESP (exactly one cycle):
  - Granted master's ack=1.
  - err=1 on slave Error or timeout.
  - rdata = VMERdData captured on the Done cycle for reads; 0 for writes, errors or timeouts.
  - Then go to IDLE and set grant to 00.
- Master rule: the master must drop req or present a new request on the edge after ack. The arbiter does not resample req until IDLE, so a minimum one-cycle gap between transfers is inherent.
- Latency: req→strobe is 1 cycle. Slave Done on strobe cycle+k (k≥0) gives ack on strobe+k+1.
- Simultaneous events:
  - Done and Error together → ack with err=1.
  - Done on the timeout cycle → Done wins; no err, no timeout_evt.
- Ignored inputs: Done/Error arriving in IDLE or RESP (stray or late) are ignored.
- Back-to-back requests:
  - Both masters requesting continuously alternate strictly: m0, m1, m0, …
  - A master requesting alone is granted repeatedly.
- Outputs: VMEAddr/VMEWrData hold their last value outside a transfer. All outputs are registered.
- Reset mid-transfer: rst_n low at any state aborts immediately; outputs go to 0 and no ack is issued. The master re-requests after reset.

Decomposition:
- Package vme_arb_pkg: state enum type (IDLE/ISSUE/WAIT/RESP), grant encoding constants (GNT_NONE, GNT_M0, GNT_M1), and the rdata error-fill constant (all zeros).
- One sub-module is natural: vme_arb_rr2, a two-input round-robin picker holding last_grant, with inputs req[1:0] and a load enable, and output one-hot grant.
- Timeout counter and FSM stay in the top module.

Test Plan:
- m0 write addr=0x00001, data=0xA5A5_00FF; slave Done 2 cycles after strobe → single VMEWrMem pulse with VMEAddr=0x00001; m0_ack at strobe+3; m0_err=0.
- m1 read addr=0x00000; slave returns 0x0000_0042 with Done 1 cycle after strobe → m1_ack at strobe+2; m1_rdata=0x0000_0042; m0 sees nothing.
- Both req high from reset for 4 transfers → grant sequence m0, m1, m0, m1; exactly one strobe per transfer; one idle cycle between them.
- Read with slave never responding, TIMEOUT=255 → ack+err on strobe+256; timeout_evt one pulse; rdata=0. A Done injected afterwards in IDLE is ignored.
- Write with VMEWrError and VMEWrDone on the same cycle → ack with err=1. A VMERdDone during a write WAIT is ignored.
- rst_n asserted in WAIT → all outputs 0 within the same cycle; after release, a new m1 request completes normally.
